conv_layer_seq: RTL and testbench

Parametrised multi-layer convolution sequencer. It walks NUM_LAYERS layers in order, running a memory-read, PE-compute and result-load handshake for each one, then pulses `done`. It sits above the per-layer memory readers and PE arrays in the conv top level. It generalises the single-layer control unit with per-layer handshake vectors, a layer index, an abort path and an optional watchdog.

---
 rtl/conv_layer_seq_if.sv | 28 ++
 rtl/conv_layer_seq.sv | 153 +++++++++++++++
 tb/tb_conv_layer_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_seq_if.sv
// Handshake bundle between the multi-layer conv sequencer and its host/datapath.
// master: the sequencer (drives strobes and status); slave: host and per-layer units.
interface conv_layer_seq_if #(
  parameter int unsigned NUM_LAYERS = 2,
  parameter int unsigned LAYER_W    = 3
);
  logic                  start;
  logic                  abort;
  logic [NUM_LAYERS-1:0] done_mem;
  logic [NUM_LAYERS-1:0] done_pe;
  logic [NUM_LAYERS-1:0] start_mem;
  logic [NUM_LAYERS-1:0] start_pe;
  logic [NUM_LAYERS-1:0] wrmem_en;
  logic [LAYER_W-1:0]    layer_idx;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    input  start, abort, done_mem, done_pe,
    output start_mem, start_pe, wrmem_en, layer_idx, busy, done, error
  );

  modport slave (
    output start, abort, done_mem, done_pe,
    input  start_mem, start_pe, wrmem_en, layer_idx, busy, done, error
  );
endinterface

// File: rtl/conv_layer_seq.sv
// Multi-layer convolution sequencer: per layer runs READ_MEM -> PE -> LD_RES,
// then pulses done. Optional watchdog enabled by defining CONV_SEQ_TIMEOUT_EN;
// without it ERR is unreachable and error is tied low.
module conv_layer_seq #(
  parameter int unsigned NUM_LAYERS     = 2,
  parameter int unsigned LAYER_W        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  conv_layer_seq_if.master      bus
);

  // Elaboration-time parameter legality check
  if (NUM_LAYERS < 1 || NUM_LAYERS > 8 || (1 << LAYER_W) < NUM_LAYERS ||
      TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("conv_layer_seq: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_READ_MEM = 3'd2,
    S_PE       = 3'd3,
    S_LD_RES   = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  state_t             state;
  logic [LAYER_W-1:0] layer_idx;
  logic               mem_hit_c;
  logic               pe_hit_c;
  logic               to_hit_c;

  // Select the done bits of the active layer; other layers are ignored
  always_comb begin
    mem_hit_c = 1'b0;
    pe_hit_c  = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (layer_idx == LAYER_W'(i)) begin
        mem_hit_c = bus.done_mem[i];
        pe_hit_c  = bus.done_pe[i];
      end
    end
  end

`ifdef CONV_SEQ_TIMEOUT_EN
  localparam int unsigned       TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  assign to_hit_c = (to_cnt == TO_LAST);

  // Wait-cycle counter: zero on entry to READ_MEM/PE, counts while the awaited done stays low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (!bus.abort &&
                 ((state == S_READ_MEM && !mem_hit_c) ||
                  (state == S_PE && !pe_hit_c))) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign to_hit_c = 1'b0;
`endif

  // Sequencer state and layer counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      layer_idx <= '0;
    end else if (bus.abort && state != S_IDLE) begin
      state     <= S_IDLE;
      layer_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          layer_idx <= '0;
          if (bus.start) state <= S_INIT;
        end
        S_INIT: begin
          if (!bus.start) state <= S_READ_MEM;
        end
        S_READ_MEM: begin
          if (mem_hit_c)     state <= S_PE;
          else if (to_hit_c) state <= S_ERR;
        end
        S_PE: begin
          if (pe_hit_c)      state <= S_LD_RES;
          else if (to_hit_c) state <= S_ERR;
        end
        S_LD_RES: begin
          if (layer_idx == LAST_LAYER) begin
            state <= S_DONE;
          end else begin
            layer_idx <= layer_idx + LAYER_W'(1);
            state     <= S_READ_MEM;
          end
        end
        S_DONE: begin
          layer_idx <= '0;
          state     <= S_IDLE;
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state     <= S_IDLE;
          layer_idx <= '0;
        end
      endcase
    end
  end

  logic [NUM_LAYERS-1:0] start_mem_c;
  logic [NUM_LAYERS-1:0] start_pe_c;
  logic [NUM_LAYERS-1:0] wrmem_en_c;

  // Moore decode of one-hot strobes from registered state and layer index
  always_comb begin
    start_mem_c = '0;
    start_pe_c  = '0;
    wrmem_en_c  = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (layer_idx == LAYER_W'(i)) begin
        start_mem_c[i] = (state == S_READ_MEM);
        start_pe_c[i]  = (state == S_PE);
        wrmem_en_c[i]  = (state == S_LD_RES);
      end
    end
  end

  assign bus.start_mem = start_mem_c;
  assign bus.start_pe  = start_pe_c;
  assign bus.wrmem_en  = wrmem_en_c;
  assign bus.layer_idx = layer_idx;
  assign bus.busy      = (state == S_INIT) || (state == S_READ_MEM) ||
                         (state == S_PE)   || (state == S_LD_RES);
  assign bus.done      = (state == S_DONE);
`ifdef CONV_SEQ_TIMEOUT_EN
  assign bus.error     = (state == S_ERR);
`else
  assign bus.error     = 1'b0;
`endif

endmodule

// File: tb/tb_conv_layer_seq.sv
// Bench for conv_layer_seq: vector table plus hand-written reset/watchdog sequences,
// expected outputs queued on drive and compared after the following clock edge.
module tb_conv_layer_seq;
  localparam int unsigned NL = 2;
  localparam int unsigned LW = 3;
  localparam int unsigned TO = 16;

  typedef struct packed {
    logic       start;
    logic       abort;
    logic [1:0] dm;
    logic [1:0] dp;
  } in_t;

  typedef struct packed {
    logic [1:0] sm;
    logic [1:0] sp;
    logic [1:0] wr;
    logic [2:0] idx;
    logic       busy;
    logic       done;
    logic       error;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv_layer_seq_if #(.NUM_LAYERS(NL), .LAYER_W(LW)) bus();

  conv_layer_seq #(.NUM_LAYERS(NL), .LAYER_W(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  out_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic in_t vi(logic s, logic a, logic [1:0] dm, logic [1:0] dp);
    in_t v;
    v.start = s; v.abort = a; v.dm = dm; v.dp = dp;
    return v;
  endfunction

  function automatic out_t vo(logic [1:0] sm, logic [1:0] sp, logic [1:0] wr,
                              logic [2:0] idx, logic busy, logic done);
    out_t o;
    o.sm = sm; o.sp = sp; o.wr = wr; o.idx = idx;
    o.busy = busy; o.done = done; o.error = 1'b0;
    return o;
  endfunction

  task automatic drive(input in_t v);
    bus.start    = v.start;
    bus.abort    = v.abort;
    bus.done_mem = v.dm;
    bus.done_pe  = v.dp;
  endtask

  task automatic compare(input string name);
    out_t got;
    out_t exp;
    got = {bus.start_mem, bus.start_pe, bus.wrmem_en, bus.layer_idx,
           bus.busy, bus.done, bus.error};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %b", name, got);
    end else begin
      exp = sb.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got sm=%b sp=%b wr=%b idx=%0d busy=%b done=%b err=%b, exp sm=%b sp=%b wr=%b idx=%0d busy=%b done=%b err=%b",
                 name, got.sm, got.sp, got.wr, got.idx, got.busy, got.done, got.error,
                 exp.sm, exp.sp, exp.wr, exp.idx, exp.busy, exp.done, exp.error);
      end
    end
  endtask

  // Drive inputs, queue the expected post-edge outputs, then sample after the edge
  task automatic step(input string name, input in_t v, input out_t e);
    drive(v);
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare(name);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    out_t idle_o;
    idle_o = vo(2'b00, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0);

    // Run A: each done returned one cycle after its strobe rises, plus stray inputs
    tbl.push_back('{vi(1,0,2'b00,2'b00), vo(2'b00,2'b00,2'b00,3'd0,1,0)});
    tbl.push_back('{vi(0,0,2'b00,2'b00), vo(2'b01,2'b00,2'b00,3'd0,1,0)});
    tbl.push_back('{vi(0,0,2'b00,2'b01), vo(2'b01,2'b00,2'b00,3'd0,1,0)});
    tbl.push_back('{vi(0,0,2'b01,2'b00), vo(2'b00,2'b01,2'b00,3'd0,1,0)});
    tbl.push_back('{vi(0,0,2'b00,2'b00), vo(2'b00,2'b01,2'b00,3'd0,1,0)});
    tbl.push_back('{vi(0,0,2'b00,2'b01), vo(2'b00,2'b00,2'b01,3'd0,1,0)});
    tbl.push_back('{vi(0,0,2'b00,2'b00), vo(2'b10,2'b00,2'b00,3'd1,1,0)});
    tbl.push_back('{vi(0,0,2'b01,2'b00), vo(2'b10,2'b00,2'b00,3'd1,1,0)});
    tbl.push_back('{vi(0,0,2'b10,2'b00), vo(2'b00,2'b10,2'b00,3'd1,1,0)});
    tbl.push_back('{vi(0,0,2'b00,2'b00), vo(2'b00,2'b10,2'b00,3'd1,1,0)});
    tbl.push_back('{vi(0,0,2'b00,2'b10), vo(2'b00,2'b00,2'b10,3'd1,1,0)});
    tbl.push_back('{vi(0,0,2'b00,2'b00), vo(2'b00,2'b00,2'b00,3'd1,0,1)});
    tbl.push_back('{vi(0,0,2'b00,2'b00), idle_o});
    tbl.push_back('{vi(0,1,2'b00,2'b00), idle_o});
    // Run B: start held 5 cycles, wrong-layer done_pe, abort beating done_mem[1]
    for (int k = 0; k < 5; k++)
      tbl.push_back('{vi(1,0,2'b00,2'b00), vo(2'b00,2'b00,2'b00,3'd0,1,0)});
    tbl.push_back('{vi(0,0,2'b00,2'b00), vo(2'b01,2'b00,2'b00,3'd0,1,0)});
    tbl.push_back('{vi(0,0,2'b01,2'b00), vo(2'b00,2'b01,2'b00,3'd0,1,0)});
    tbl.push_back('{vi(0,0,2'b00,2'b10), vo(2'b00,2'b01,2'b00,3'd0,1,0)});
    tbl.push_back('{vi(0,0,2'b00,2'b01), vo(2'b00,2'b00,2'b01,3'd0,1,0)});
    tbl.push_back('{vi(0,0,2'b00,2'b00), vo(2'b10,2'b00,2'b00,3'd1,1,0)});
    tbl.push_back('{vi(0,1,2'b10,2'b00), idle_o});
    tbl.push_back('{vi(0,0,2'b10,2'b00), idle_o});
    tbl.push_back('{vi(0,0,2'b00,2'b00), idle_o});
    // Run C: minimum-length run with dones held high, start high through DONE
    tbl.push_back('{vi(1,0,2'b11,2'b11), vo(2'b00,2'b00,2'b00,3'd0,1,0)});
    tbl.push_back('{vi(0,0,2'b11,2'b11), vo(2'b01,2'b00,2'b00,3'd0,1,0)});
    tbl.push_back('{vi(0,0,2'b11,2'b11), vo(2'b00,2'b01,2'b00,3'd0,1,0)});
    tbl.push_back('{vi(0,0,2'b11,2'b11), vo(2'b00,2'b00,2'b01,3'd0,1,0)});
    tbl.push_back('{vi(0,0,2'b11,2'b11), vo(2'b10,2'b00,2'b00,3'd1,1,0)});
    tbl.push_back('{vi(0,0,2'b11,2'b11), vo(2'b00,2'b10,2'b00,3'd1,1,0)});
    tbl.push_back('{vi(0,0,2'b11,2'b11), vo(2'b00,2'b00,2'b10,3'd1,1,0)});
    tbl.push_back('{vi(1,0,2'b11,2'b11), vo(2'b00,2'b00,2'b00,3'd1,0,1)});
    tbl.push_back('{vi(1,0,2'b11,2'b11), idle_o});
    tbl.push_back('{vi(1,0,2'b11,2'b11), vo(2'b00,2'b00,2'b00,3'd0,1,0)});
    tbl.push_back('{vi(0,1,2'b00,2'b00), idle_o});
    tbl.push_back('{vi(0,0,2'b00,2'b00), idle_o});

    drive(vi(0, 0, 2'b00, 2'b00));
    #12;
    sb.push_back(idle_o);
    compare("reset_state");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < tbl.size(); k++)
      step($sformatf("vec%0d", k), tbl[k].in, tbl[k].exp);

    // Asynchronous reset in the middle of a PE wait
    step("rst_init", vi(1,0,2'b00,2'b00), vo(2'b00,2'b00,2'b00,3'd0,1,0));
    step("rst_rm0",  vi(0,0,2'b00,2'b00), vo(2'b01,2'b00,2'b00,3'd0,1,0));
    step("rst_pe0",  vi(0,0,2'b01,2'b00), vo(2'b00,2'b01,2'b00,3'd0,1,0));
    drive(vi(0, 0, 2'b00, 2'b00));
    #2;
    rst = 1'b1;
    #1;
    sb.push_back(idle_o);
    compare("rst_async_drop");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    sb.push_back(idle_o);
    compare("rst_release_idle");

`ifdef CONV_SEQ_TIMEOUT_EN
    // Watchdog: done_mem never returns, ERR after TO cycles of READ_MEM
    begin
      out_t err_o;
      err_o = idle_o;
      err_o.error = 1'b1;
      step("to_init", vi(1,0,2'b00,2'b00), vo(2'b00,2'b00,2'b00,3'd0,1,0));
      step("to_rm_1", vi(0,0,2'b00,2'b00), vo(2'b01,2'b00,2'b00,3'd0,1,0));
      for (int k = 2; k <= TO; k++)
        step($sformatf("to_rm_%0d", k), vi(0,0,2'b00,2'b00), vo(2'b01,2'b00,2'b00,3'd0,1,0));
      step("to_err", vi(0,0,2'b00,2'b00), err_o);
      for (int k = 0; k < 3; k++)
        step($sformatf("to_err_hold%0d", k), vi(1,0,2'b11,2'b11), err_o);
      step("to_abort", vi(0,1,2'b00,2'b00), idle_o);
    end
`endif

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
